// File: rtl/l2_cache_pkg.sv
// Shared definitions for the L2 set-associative cache and its benches.
//   - default parameter constants (word width, index bits, line words, ways)
//   - controller state encoding
//   - l2_way_bits(): width of a way number (at least 1 bit, so WAYS=1 works)
package l2_cache_pkg;

  localparam int L2_N            = 32;
  localparam int L2_INDEXWIDTH   = 8;
  localparam int L2_WORDSPERLINE = 2;
  localparam int L2_WAYS         = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_EVICT,
    ST_FILL,
    ST_RESPOND
  } l2_state_e;

  function automatic int l2_way_bits(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/l2_line_ram.sv
// One way of cache line data: single clock, one write port, one registered
// read port. Contents are not reset.
//   clk    : clock
//   we     : write enable
//   waddr  : write set index
//   wdata  : write line
//   raddr  : read set index (data appears the cycle after)
//   rdata  : registered read line
module l2_line_ram
  import l2_cache_pkg::*;
#(
  parameter int W  = L2_WORDSPERLINE * L2_N,
  parameter int AW = L2_INDEXWIDTH
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [1<<AW];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/l2_sa_cache.sv
// Set-associative write-back, write-allocate L2 cache controller.
//   clk, rst                : clock, asynchronous active-high reset
//   req_valid/req_ready     : L1 request handshake (ready only when idle)
//   req_we/addr/wdata       : whole-line write or line read
//   resp_valid/resp_rdata   : one-cycle completion pulse, read line (else 0)
//   mem_req/we/addr/wdata   : memory write-back or fill, held until mem_ack
//   mem_ack/mem_rdata       : memory completion, fill line same cycle
module l2_sa_cache
  import l2_cache_pkg::*;
#(
  parameter int N            = L2_N,
  parameter int INDEXWIDTH   = L2_INDEXWIDTH,
  parameter int WORDSPERLINE = L2_WORDSPERLINE,
  parameter int WAYS         = L2_WAYS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [N-1:0]              req_addr,
  input  logic [WORDSPERLINE*N-1:0] req_wdata,
  output logic                      resp_valid,
  output logic [WORDSPERLINE*N-1:0] resp_rdata,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [N-1:0]              mem_addr,
  output logic [WORDSPERLINE*N-1:0] mem_wdata,
  input  logic                      mem_ack,
  input  logic [WORDSPERLINE*N-1:0] mem_rdata
);

  localparam int LW   = WORDSPERLINE * N;
  localparam int SETS = 1 << INDEXWIDTH;
  localparam int TW   = N - INDEXWIDTH;
  localparam int WB   = l2_way_bits(WAYS);

  l2_state_e         state_q, state_d;
  logic              we_q, we_d;
  logic [N-1:0]      addr_q, addr_d;
  logic [LW-1:0]     wdata_q, wdata_d;
  logic [WB-1:0]     victim_q, victim_d;
  logic              resp_valid_q, resp_valid_d;
  logic [LW-1:0]     resp_rdata_q, resp_rdata_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [N-1:0]      mem_addr_q, mem_addr_d;
  logic [LW-1:0]     mem_wdata_q, mem_wdata_d;

  logic [WAYS-1:0][SETS-1:0] valid_q, dirty_q;
  logic [SETS-1:0][WB-1:0]   rr_q;
  logic [TW-1:0]             tag_q [WAYS][SETS];

  logic [INDEXWIDTH-1:0] idx;
  logic [TW-1:0]         tag;
  assign idx = addr_q[INDEXWIDTH-1:0];
  assign tag = addr_q[N-1:INDEXWIDTH];

  // Tag match and victim choice for the latched request's set.
  logic          hit, any_inv, victim_dirty;
  logic [WB-1:0] hit_way, inv_way, victim, rr_nxt;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    any_inv = 1'b0;
    inv_way = '0;
    // Descending scan so the lowest-numbered invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[w][idx] && (tag_q[w][idx] == tag)) begin
        hit     = 1'b1;
        hit_way = WB'(w);
      end
      if (!valid_q[w][idx]) begin
        any_inv = 1'b1;
        inv_way = WB'(w);
      end
    end
    victim       = any_inv ? inv_way : rr_q[idx];
    victim_dirty = valid_q[victim][idx] && dirty_q[victim][idx];
    rr_nxt       = (WAYS == 1) ? '0 : rr_q[idx] + WB'(1);
  end

  // Line data RAMs. While idle the read address follows the incoming
  // request so every way's line is ready in LOOKUP; afterwards it stays on
  // the latched set so the victim line is still there for a write-back.
  logic [INDEXWIDTH-1:0]   ram_raddr;
  logic [WAYS-1:0]         ram_we;
  logic [LW-1:0]           ram_wdata;
  logic [WAYS-1:0][LW-1:0] ram_rdata;

  // Line update request from the FSM: write data into one way; on
  // allocation also install tag/valid and step the round-robin pointer.
  logic          line_wr, line_alloc, line_dirty;
  logic [WB-1:0] line_way;

  assign ram_raddr = (state_q == ST_IDLE) ? req_addr[INDEXWIDTH-1:0] : idx;

  always_comb begin
    for (int w = 0; w < WAYS; w++) ram_we[w] = line_wr && (line_way == WB'(w));
  end

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    l2_line_ram #(.W(LW), .AW(INDEXWIDTH)) u_ram (
      .clk   (clk),
      .we    (ram_we[g]),
      .waddr (idx),
      .wdata (ram_wdata),
      .raddr (ram_raddr),
      .rdata (ram_rdata[g])
    );
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    victim_d     = victim_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    line_wr      = 1'b0;
    line_alloc   = 1'b0;
    line_dirty   = 1'b0;
    line_way     = victim_q;
    ram_wdata    = wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        victim_d = victim;
        if (hit) begin
          resp_valid_d = 1'b1;
          state_d      = ST_RESPOND;
          if (we_q) begin
            line_wr    = 1'b1;
            line_way   = hit_way;
            line_dirty = 1'b1;
          end else begin
            resp_rdata_d = ram_rdata[hit_way];
          end
        end else if (victim_dirty) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = {tag_q[victim][idx], idx};
          mem_wdata_d = ram_rdata[victim];
          state_d     = ST_EVICT;
        end else if (we_q) begin
          line_wr      = 1'b1;
          line_alloc   = 1'b1;
          line_way     = victim;
          line_dirty   = 1'b1;
          resp_valid_d = 1'b1;
          state_d      = ST_RESPOND;
        end else begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = addr_q;
          state_d    = ST_FILL;
        end
      end
      ST_EVICT: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (we_q) begin
            line_wr      = 1'b1;
            line_alloc   = 1'b1;
            line_dirty   = 1'b1;
            resp_valid_d = 1'b1;
            state_d      = ST_RESPOND;
          end else begin
            mem_we_d   = 1'b0;
            mem_addr_d = addr_q;
            state_d    = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        // After a write-back mem_req drops for one cycle, then the fill is
        // raised; acks are only honoured while the request is up.
        if (!mem_req_q) begin
          mem_req_d = 1'b1;
        end else if (mem_ack) begin
          mem_req_d    = 1'b0;
          line_wr      = 1'b1;
          line_alloc   = 1'b1;
          ram_wdata    = mem_rdata;
          resp_valid_d = 1'b1;
          resp_rdata_d = mem_rdata;
          state_d      = ST_RESPOND;
        end
      end
      ST_RESPOND: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      victim_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      valid_q      <= '0;
      dirty_q      <= '0;
      rr_q         <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      victim_q     <= victim_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if (line_wr) begin
        dirty_q[line_way][idx] <= line_dirty;
        if (line_alloc) begin
          valid_q[line_way][idx] <= 1'b1;
          rr_q[idx]              <= rr_nxt;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (line_wr && line_alloc) tag_q[line_way][idx] <= tag;
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_l2_sa_cache.sv
module tb_l2_sa_cache;
  import l2_cache_pkg::*;

  localparam logic [63:0] D1  = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] D2  = 64'h2222_2222_0000_0200;
  localparam logic [63:0] D3  = 64'h3333_3333_0000_0300;
  localparam logic [63:0] W1  = 64'h0000_0000_1111_2222;
  localparam logic [63:0] D2B = 64'h0000_0201_0000_0201;
  localparam logic [63:0] D3B = 64'h0000_0301_0000_0301;
  localparam logic [63:0] W2  = 64'h5A5A_5A5A_0000_0103;
  localparam logic [63:0] D23 = 64'h0000_0203_0000_0203;
  localparam logic [63:0] D33 = 64'h0000_0303_0000_0303;
  localparam logic [63:0] WH  = 64'hCAFE_F00D_0000_0300;
  localparam logic [63:0] D5  = 64'h5555_5555_0000_0500;
  localparam logic [63:0] W4  = 64'h4444_0000_4444_0400;

  logic        clk, rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  l2_sa_cache dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One L1 transaction with the memory behaviour and everything expected.
  typedef struct {
    bit          we;
    bit [31:0]   addr;
    bit [63:0]   wdata;
    int          dly;        // cycles mem_ack is withheld per memory request
    bit [63:0]   fdata;      // line returned on fill
    int          exp_nev;
    bit [31:0]   ev_addr;
    bit [63:0]   ev_data;
    int          exp_nfill;
    bit [31:0]   fill_addr;
    bit [63:0]   exp_rdata;
    int          exp_lat;    // cycles from acceptance edge to resp_valid
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_txn(input vec_t v, input int id);
    int          cyc, wc, nev, nfill, errs, lat;
    bit          done;
    logic [63:0] rd, ev_d, s_d;
    logic [31:0] ev_a, f_a, s_a;
    logic        s_we;
    cyc = 0; wc = 0; nev = 0; nfill = 0; errs = 0; lat = 0; done = 0;
    rd = '0; ev_d = '0; s_d = '0; ev_a = '0; f_a = '0; s_a = '0; s_we = 0;
    @(negedge clk);
    check($sformatf("v%0d_ready", id), req_ready, 1);
    req_valid = 1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk);
    while (!done && cyc < 80) begin
      @(negedge clk);
      cyc++;
      req_valid = 0;
      mem_ack   = 0;
      if (req_ready) errs++;
      if (resp_valid) begin
        done = 1; rd = resp_rdata; lat = cyc;
        if (mem_req) errs++;
      end else if (mem_req) begin
        if (wc == 0) begin
          s_a = mem_addr; s_we = mem_we; s_d = mem_wdata;
          if (mem_we) begin nev++; ev_a = mem_addr; ev_d = mem_wdata; end
          else begin nfill++; f_a = mem_addr; end
        end else if (mem_addr !== s_a || mem_we !== s_we || (s_we && mem_wdata !== s_d)) begin
          errs++;
        end
        if (wc == v.dly) begin
          mem_ack = 1; mem_rdata = v.fdata; wc = 0;
        end else begin
          wc++;
        end
      end
    end
    mem_ack = 0;
    check($sformatf("v%0d_done", id), done, 1);
    check($sformatf("v%0d_rdata", id), rd, v.exp_rdata);
    check($sformatf("v%0d_latency", id), lat, v.exp_lat);
    check($sformatf("v%0d_nevict", id), nev, v.exp_nev);
    check($sformatf("v%0d_nfill", id), nfill, v.exp_nfill);
    check($sformatf("v%0d_hold", id), errs, 0);
    if (v.exp_nev > 0) begin
      check($sformatf("v%0d_ev_addr", id), ev_a, v.ev_addr);
      check($sformatf("v%0d_ev_data", id), ev_d, v.ev_data);
    end
    if (v.exp_nfill > 0) check($sformatf("v%0d_fill_addr", id), f_a, v.fill_addr);
  endtask

  vec_t vecs[17];
  vec_t v;

  initial begin
    vecs = '{
      //  we addr    wdata dly fdata nev evaddr  evdata nfil filaddr rdata lat
      '{0, 'h100, 0,  0, D1,  0, 0,     0,  1, 'h100, D1,  3},  // cold miss
      '{0, 'h100, 0,  0, 0,   0, 0,     0,  0, 0,     D1,  2},  // re-read hit
      '{0, 'h200, 0,  0, D2,  0, 0,     0,  1, 'h200, D2,  3},
      '{0, 'h300, 0,  0, D3,  0, 0,     0,  1, 'h300, D3,  3},  // clean evict way0
      '{0, 'h200, 0,  0, 0,   0, 0,     0,  0, 0,     D2,  2},  // still hits
      '{0, 'h100, 0,  0, D1,  0, 0,     0,  1, 'h100, D1,  3},  // evicts 0x200 (way1)
      '{1, 'h101, W1, 0, 0,   0, 0,     0,  0, 0,     0,   2},  // write miss, empty set
      '{0, 'h101, 0,  0, 0,   0, 0,     0,  0, 0,     W1,  2},  // read after write
      '{0, 'h201, 0,  0, D2B, 0, 0,     0,  1, 'h201, D2B, 3},
      '{0, 'h301, 0,  0, D3B, 1, 'h101, W1, 1, 'h301, D3B, 5},  // dirty write-back
      '{0, 'h101, 0,  0, W1,  0, 0,     0,  1, 'h101, W1,  3},
      '{1, 'h103, W2, 0, 0,   0, 0,     0,  0, 0,     0,   2},
      '{0, 'h203, 0,  0, D23, 0, 0,     0,  1, 'h203, D23, 3},
      '{0, 'h303, 0,  5, D33, 1, 'h103, W2, 1, 'h303, D33, 15}, // slow memory
      '{1, 'h300, WH, 0, 0,   0, 0,     0,  0, 0,     0,   2},  // write hit
      '{0, 'h100, 0,  0, 0,   0, 0,     0,  0, 0,     D1,  2},
      '{0, 'h200, 0,  0, D2,  1, 'h300, WH, 1, 'h200, D2,  5}   // write-hit line now dirty
    };

    rst = 1; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0;
    mem_ack = 0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("rst_req_ready",  req_ready,  1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_mem_req",    mem_req,    0);
    check("rst_mem_we",     mem_we,     0);
    check("rst_mem_addr",   mem_addr,   0);
    check("rst_mem_wdata",  mem_wdata,  0);

    for (int i = 0; i < 17; i++) do_txn(vecs[i], i);

    // Reset while a fill is outstanding.
    @(negedge clk);
    req_valid = 1; req_we = 0; req_addr = 32'h500;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    check("fill_mem_req", mem_req, 1);
    check("fill_mem_addr", mem_addr, 32'h500);
    #2 rst = 1;
    #1;
    check("rst_async_mem_req", mem_req, 0);
    check("rst_async_ready", req_ready, 1);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("post_rst_ready", req_ready, 1);
    check("post_rst_mem_req", mem_req, 0);

    v = '{0, 'h500, 0, 0, D5, 0, 0, 0, 1, 'h500, D5, 3};  // misses again
    do_txn(v, 100);
    v = '{1, 'h400, W4, 0, 0, 0, 0, 0, 0, 0, 0, 2};       // write miss, no memory
    do_txn(v, 101);
    v = '{0, 'h400, 0, 0, 0, 0, 0, 0, 0, 0, W4, 2};       // reads written line
    do_txn(v, 102);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
